// File: rtl/line_ctrl_pkg.sv
// Shared types and constants for the line-following motor controller.
// The duty helper limits a signed duty request to the PWM range.
package line_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_COAST = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   typedef logic signed [11:0] err_t;

   localparam int DUTY_W = 12;

   function automatic logic [DUTY_W-1:0] clamp_duty(input logic signed [12:0] val,
                                                    input int max_duty);
      if (val[12]) return '0;
      else if (int'(val) > max_duty) return DUTY_W'(max_duty);
      else return val[DUTY_W-1:0];
   endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with shadowed duties for both motor channels.
// New duties take effect only at the period boundary so no pulse is cut short.
module pwm_gen
   import line_ctrl_pkg::*;
#(
   parameter int PWM_PERIOD = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DUTY_W-1:0] duty_left,
   input  logic [DUTY_W-1:0] duty_right,
   output logic              pwm_left,
   output logic              pwm_right
);

   logic [DUTY_W-1:0] cnt;
   logic [DUTY_W-1:0] act_left;
   logic [DUTY_W-1:0] act_right;
   logic              wrap;

   assign wrap = (cnt == DUTY_W'(PWM_PERIOD - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         act_left  <= '0;
         act_right <= '0;
      end else if (wrap) begin
         cnt       <= '0;
         act_left  <= duty_left;
         act_right <= duty_right;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign pwm_left  = en & (cnt < act_left);
   assign pwm_right = en & (cnt < act_right);

endmodule

// File: rtl/line_follow_ctrl.sv
// Steers a two-motor robot from per-frame line centroids: proportional
// differential drive, coast through brief line loss, stop after sustained loss.
module line_follow_ctrl
   import line_ctrl_pkg::*;
#(
   parameter int IMG_W       = 640,
   parameter int PWM_PERIOD  = 1000,
   parameter int BASE_DUTY   = 600,
   parameter int KP_SHIFT    = 1,
   parameter int DEADBAND    = 8,
   parameter int LOST_FRAMES = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               frame_done,
   input  logic [10:0]        centroid_x,
   input  logic               line_valid,
   input  logic               line_lost,
   output logic               pwm_left,
   output logic               pwm_right,
   output logic               motor_en,
   output logic [1:0]         state_o,
   output logic signed [11:0] steer_err
);

   localparam int HALF_W = IMG_W / 2;
   localparam int LCNT_W = $clog2(LOST_FRAMES + 1);
   localparam logic [LCNT_W-1:0] LOST_MAX = LCNT_W'(LOST_FRAMES);

   state_t             state, state_nxt;
   logic [LCNT_W-1:0]  lost_cnt, lost_nxt, lost_inc;
   logic               good_frame, lost_frame, load_err;
   err_t               err_raw, err_db, err_shr;
   logic [12:0]        err_abs;
   logic signed [12:0] err_ext, base_s, sum_left, sum_right;
   logic [DUTY_W-1:0]  tgt_left, tgt_right;

   // frame_done is a one-cycle strobe with no backpressure: the centroid,
   // line_valid and line_lost are consumed on exactly the cycle it is high.
   assign good_frame = frame_done & line_valid & ~line_lost;
   assign lost_frame = frame_done & ~good_frame;

   always_comb begin
      err_raw   = err_t'({1'b0, centroid_x} - 12'(HALF_W));
      err_abs   = err_raw[11] ? (~{err_raw[11], err_raw} + 13'd1) : {1'b0, err_raw};
      err_db    = (int'(err_abs) < DEADBAND) ? '0 : err_raw;
      err_shr   = err_db >>> KP_SHIFT;
      err_ext   = {err_shr[11], err_shr};
      base_s    = 13'(BASE_DUTY);
      sum_left  = base_s + err_ext;
      sum_right = base_s - err_ext;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      lost_nxt  = lost_cnt;
      load_err  = 1'b0;
      lost_inc  = (lost_cnt < LOST_MAX) ? lost_cnt + 1'b1 : lost_cnt;
      case (state)
         ST_IDLE: begin
            if (enable) state_nxt = ST_TRACK;
         end
         ST_TRACK, ST_COAST: begin
            if (good_frame) begin
               load_err  = 1'b1;
               lost_nxt  = '0;
               state_nxt = ST_TRACK;
            end else if (lost_frame) begin
               // the frame that drops TRACK into COAST counts as the first loss
               lost_nxt  = lost_inc;
               state_nxt = (lost_inc >= LOST_MAX) ? ST_STOP : ST_COAST;
            end
         end
         ST_STOP: begin
            if (good_frame) begin
               load_err  = 1'b1;
               lost_nxt  = '0;
               state_nxt = ST_TRACK;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (!enable) begin
         state_nxt = ST_IDLE;
         lost_nxt  = '0;
         load_err  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lost_cnt  <= '0;
         steer_err <= '0;
         tgt_left  <= '0;
         tgt_right <= '0;
      end else begin
         lost_cnt <= lost_nxt;
         if (load_err) begin
            steer_err <= err_db;
            tgt_left  <= clamp_duty(sum_left, PWM_PERIOD);
            tgt_right <= clamp_duty(sum_right, PWM_PERIOD);
         end else if (state_nxt == ST_IDLE || state_nxt == ST_STOP) begin
            tgt_left  <= '0;
            tgt_right <= '0;
         end
      end
   end

   assign state_o  = state;
   assign motor_en = (state == ST_TRACK) || (state == ST_COAST);

   pwm_gen #(
      .PWM_PERIOD(PWM_PERIOD)
   ) u_pwm (
      .clk       (clk),
      .rst       (rst),
      .en        (motor_en),
      .duty_left (tgt_left),
      .duty_right(tgt_right),
      .pwm_left  (pwm_left),
      .pwm_right (pwm_right)
   );

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Bench for line_follow_ctrl: directed scenarios plus random frames checked
// against a frame-level behavioural model; a second instance uses BASE_DUTY=900.
module tb_line_follow_ctrl;

   localparam int P      = 1000;
   localparam int IMG_W  = 640;
   localparam int BASE   = 600;
   localparam int BASE_B = 900;
   localparam int KP     = 1;
   localparam int DB     = 8;
   localparam int LF     = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0;
   logic frame_done = 1'b0;
   logic line_valid = 1'b0;
   logic line_lost = 1'b0;
   logic [10:0] centroid_x = '0;

   logic pwm_left, pwm_right, motor_en;
   logic [1:0] state_o;
   logic signed [11:0] steer_err;
   logic pwm_left_b, pwm_right_b, motor_en_b;
   logic [1:0] state_o_b;
   logic signed [11:0] steer_err_b;

   line_follow_ctrl #(.IMG_W(IMG_W), .PWM_PERIOD(P), .BASE_DUTY(BASE), .KP_SHIFT(KP),
                      .DEADBAND(DB), .LOST_FRAMES(LF)) dut (
      .clk(clk), .rst(rst), .enable(enable), .frame_done(frame_done),
      .centroid_x(centroid_x), .line_valid(line_valid), .line_lost(line_lost),
      .pwm_left(pwm_left), .pwm_right(pwm_right), .motor_en(motor_en),
      .state_o(state_o), .steer_err(steer_err));

   line_follow_ctrl #(.IMG_W(IMG_W), .PWM_PERIOD(P), .BASE_DUTY(BASE_B), .KP_SHIFT(KP),
                      .DEADBAND(DB), .LOST_FRAMES(LF)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .frame_done(frame_done),
      .centroid_x(centroid_x), .line_valid(line_valid), .line_lost(line_lost),
      .pwm_left(pwm_left_b), .pwm_right(pwm_right_b), .motor_en(motor_en_b),
      .state_o(state_o_b), .steer_err(steer_err_b));

   // clock / reset
   always #5 clk = ~clk;

   // position within the PWM period, from the period rule alone
   int pcnt = 0;
   always @(posedge clk) begin
      if (rst) pcnt <= 0;
      else     pcnt <= (pcnt == P - 1) ? 0 : pcnt + 1;
   end

   // frame-level model: 0 idle, 1 track, 2 coast, 3 stop
   int m_state, m_lost, m_err, m_tl, m_tr, m_tl_b, m_tr_b;
   int n_checks = 0;
   int n_pass = 0;

   function automatic int ref_err(input int cx);
      int e;
      e = cx - IMG_W / 2;
      if (e > -DB && e < DB) e = 0;
      return e;
   endfunction

   function automatic int ref_duty(input int base, input int e, input bit left);
      int d;
      d = left ? base + (e >>> KP) : base - (e >>> KP);
      if (d < 0) d = 0;
      if (d > P) d = P;
      return d;
   endfunction

   task automatic model_reset();
      m_state = 0; m_lost = 0; m_err = 0;
      m_tl = 0; m_tr = 0; m_tl_b = 0; m_tr_b = 0;
   endtask

   task automatic model_frame(input int cx, input bit v, input bit l);
      if (m_state == 0) return;
      if (v && !l) begin
         m_err  = ref_err(cx);
         m_tl   = ref_duty(BASE, m_err, 1'b1);
         m_tr   = ref_duty(BASE, m_err, 1'b0);
         m_tl_b = ref_duty(BASE_B, m_err, 1'b1);
         m_tr_b = ref_duty(BASE_B, m_err, 1'b0);
         m_state = 1;
         m_lost = 0;
      end else if (m_state == 1 || m_state == 2) begin
         m_lost = (m_lost < LF) ? m_lost + 1 : LF;
         if (m_lost >= LF) begin
            m_state = 3;
            m_tl = 0; m_tr = 0; m_tl_b = 0; m_tr_b = 0;
         end else begin
            m_state = 2;
         end
      end
   endtask

   // driver tasks
   task automatic send_frame(input int cx, input bit v, input bit l);
      @(negedge clk);
      centroid_x = 11'(cx);
      line_valid = v;
      line_lost  = l;
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
      model_frame(cx, v, l);
   endtask

   task automatic wait_cnt(input int n);
      int k;
      k = 0;
      while (pcnt != n && k < 2 * P) begin
         @(negedge clk);
         k++;
      end
      if (pcnt != n) begin
         n_checks++;
         $display("FAIL wait_cnt: timed out at counter %0d, wanted %0d", pcnt, n);
      end
   endtask

   // counts high cycles over one full PWM period that starts after the next wrap
   task automatic measure(output int hl, output int hr, output int hlb, output int hrb);
      @(negedge clk);
      wait_cnt(0);
      hl = 0; hr = 0; hlb = 0; hrb = 0;
      for (int i = 0; i < P; i++) begin
         if (pwm_left === 1'b1)    hl++;
         if (pwm_right === 1'b1)   hr++;
         if (pwm_left_b === 1'b1)  hlb++;
         if (pwm_right_b === 1'b1) hrb++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      model_reset();
      n_checks++; if (state_o !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_o); else n_pass++;
      n_checks++; if (steer_err !== 12'sd0) $display("FAIL reset_err: got %0d want 0", steer_err); else n_pass++;
      n_checks++; if ({motor_en, pwm_left, pwm_right} !== 3'b000)
         $display("FAIL reset_outputs: got %b want 000", {motor_en, pwm_left, pwm_right}); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_center();
      int hl, hr, hlb, hrb;
      enable = 1'b1;
      @(negedge clk);
      m_state = 1;
      n_checks++; if (state_o !== 2'd1) $display("FAIL enable_track: got %0d want 1", state_o); else n_pass++;
      n_checks++; if (motor_en !== 1'b1) $display("FAIL enable_motor: got %b want 1", motor_en); else n_pass++;
      send_frame(320, 1'b1, 1'b0);
      n_checks++; if (steer_err !== 12'sd0) $display("FAIL center_err: got %0d want 0", steer_err); else n_pass++;
      measure(hl, hr, hlb, hrb);
      n_checks++; if (hl != 600 || hr != 600)
         $display("FAIL center_duty: got %0d/%0d want 600/600", hl, hr); else n_pass++;
   endtask

   task automatic test_next_wrap();
      int hl, hr, hlb, hrb;
      wait_cnt(200);
      send_frame(520, 1'b1, 1'b0);
      n_checks++; if (steer_err !== 12'sd200) $display("FAIL wrap_err: got %0d want 200", steer_err); else n_pass++;
      wait_cnt(550);
      n_checks++; if (pwm_right !== 1'b1) $display("FAIL wrap_right_old: got %b want 1", pwm_right); else n_pass++;
      wait_cnt(650);
      n_checks++; if (pwm_left !== 1'b0) $display("FAIL wrap_left_old: got %b want 0", pwm_left); else n_pass++;
      measure(hl, hr, hlb, hrb);
      n_checks++; if (hl != 700 || hr != 500)
         $display("FAIL wrap_new_duty: got %0d/%0d want 700/500", hl, hr); else n_pass++;
   endtask

   task automatic test_clamp();
      int hl, hr, hlb, hrb;
      send_frame(639, 1'b1, 1'b0);
      n_checks++; if (steer_err_b !== 12'sd319) $display("FAIL clamp_err: got %0d want 319", steer_err_b); else n_pass++;
      measure(hl, hr, hlb, hrb);
      n_checks++; if (hlb != 1000 || hrb != 741)
         $display("FAIL clamp_duty_b: got %0d/%0d want 1000/741", hlb, hrb); else n_pass++;
      n_checks++; if (hl != m_tl || hr != m_tr)
         $display("FAIL clamp_duty_a: got %0d/%0d want %0d/%0d", hl, hr, m_tl, m_tr); else n_pass++;
   endtask

   task automatic test_lost();
      int hl, hr, hlb, hrb;
      for (int i = 0; i < 7; i++) send_frame(100, 1'b0, 1'b0);
      n_checks++; if (state_o !== 2'd2) $display("FAIL lost7_state: got %0d want 2", state_o); else n_pass++;
      measure(hl, hr, hlb, hrb);
      n_checks++; if (hl != 759 || hr != 441)
         $display("FAIL coast_hold: got %0d/%0d want 759/441", hl, hr); else n_pass++;
      send_frame(100, 1'b0, 1'b0);
      n_checks++; if (state_o !== 2'd3) $display("FAIL lost8_state: got %0d want 3", state_o); else n_pass++;
      n_checks++; if (motor_en !== 1'b0) $display("FAIL stop_motor: got %b want 0", motor_en); else n_pass++;
      measure(hl, hr, hlb, hrb);
      n_checks++; if (hl != 0 || hr != 0) $display("FAIL stop_pwm: got %0d/%0d want 0/0", hl, hr); else n_pass++;
      send_frame(330, 1'b1, 1'b0);
      n_checks++; if (state_o !== 2'd1) $display("FAIL recover_state: got %0d want 1", state_o); else n_pass++;
      n_checks++; if (steer_err !== 12'sd10) $display("FAIL recover_err: got %0d want 10", steer_err); else n_pass++;
      measure(hl, hr, hlb, hrb);
      n_checks++; if (hl != 605 || hr != 595)
         $display("FAIL recover_duty: got %0d/%0d want 605/595", hl, hr); else n_pass++;
   endtask

   task automatic test_both_flags();
      send_frame(400, 1'b1, 1'b1);
      n_checks++; if (state_o !== 2'd2) $display("FAIL both_flags_state: got %0d want 2", state_o); else n_pass++;
      n_checks++; if (steer_err !== 12'(m_err)) $display("FAIL both_flags_err: got %0d want %0d", steer_err, m_err); else n_pass++;
      send_frame(400, 1'b1, 1'b0);
      n_checks++; if (state_o !== 2'd1) $display("FAIL both_flags_back: got %0d want 1", state_o); else n_pass++;
   endtask

   task automatic test_deadband();
      int cx_tab[5];
      int want_tab[5];
      cx_tab   = '{327, 313, 312, 328, 320};
      want_tab = '{0, 0, -8, 8, 0};
      for (int i = 0; i < 5; i++) begin
         send_frame(cx_tab[i], 1'b1, 1'b0);
         n_checks++; if (steer_err !== 12'(want_tab[i]))
            $display("FAIL deadband_cx%0d: got %0d want %0d", cx_tab[i], steer_err, want_tab[i]); else n_pass++;
      end
   endtask

   task automatic test_mid_reset();
      send_frame(330, 1'b1, 1'b0);
      @(negedge clk);
      wait_cnt(0);
      wait_cnt(100);
      n_checks++; if (pwm_left !== 1'b1) $display("FAIL prereset_pwm: got %b want 1", pwm_left); else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      n_checks++; if ({pwm_left, pwm_right, motor_en} !== 3'b000)
         $display("FAIL midreset_out: got %b want 000", {pwm_left, pwm_right, motor_en}); else n_pass++;
      n_checks++; if (state_o !== 2'd0 || steer_err !== 12'sd0)
         $display("FAIL midreset_state: got %0d/%0d want 0/0", state_o, steer_err); else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      m_state = 1;
      @(negedge clk);
      n_checks++; if (state_o !== 2'd1 || pwm_left !== 1'b0)
         $display("FAIL postreset: got state %0d pwm %b want 1/0", state_o, pwm_left); else n_pass++;
   endtask

   task automatic test_disable();
      int hl, hr, hlb, hrb;
      send_frame(330, 1'b1, 1'b0);
      measure(hl, hr, hlb, hrb);
      wait_cnt(50);
      n_checks++; if (pwm_left !== 1'b1) $display("FAIL predisable_pwm: got %b want 1", pwm_left); else n_pass++;
      enable = 1'b0;
      @(negedge clk);
      m_state = 0; m_lost = 0; m_tl = 0; m_tr = 0; m_tl_b = 0; m_tr_b = 0;
      n_checks++; if ({pwm_left, pwm_right, motor_en} !== 3'b000 || state_o !== 2'd0)
         $display("FAIL disable: got out %b state %0d want 000/0", {pwm_left, pwm_right, motor_en}, state_o); else n_pass++;
      send_frame(520, 1'b1, 1'b0);
      n_checks++; if (state_o !== 2'd0 || steer_err !== 12'(m_err))
         $display("FAIL idle_ignore: got state %0d err %0d want 0/%0d", state_o, steer_err, m_err); else n_pass++;
   endtask

   task automatic test_random();
      int hl, hr, hlb, hrb;
      int cx;
      bit v, l;
      enable = 1'b1;
      @(negedge clk);
      m_state = 1;
      for (int i = 0; i < 30; i++) begin
         cx = $urandom_range(0, 1023);
         v  = ($urandom_range(0, 3) != 0);
         l  = ($urandom_range(0, 3) == 0);
         send_frame(cx, v, l);
         n_checks++; if (state_o !== 2'(m_state) || steer_err !== 12'(m_err))
            $display("FAIL rand%0d: got state %0d err %0d want %0d/%0d", i, state_o, steer_err, m_state, m_err); else n_pass++;
         if (i % 10 == 9) begin
            measure(hl, hr, hlb, hrb);
            n_checks++;
            if (m_state == 1 || m_state == 2) begin
               if (hl != m_tl || hr != m_tr || hlb != m_tl_b || hrb != m_tr_b)
                  $display("FAIL rand_duty%0d: got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d",
                           i, hl, hr, hlb, hrb, m_tl, m_tr, m_tl_b, m_tr_b);
               else n_pass++;
            end else begin
               if (hl != 0 || hr != 0) $display("FAIL rand_duty%0d: got %0d/%0d want 0/0", i, hl, hr);
               else n_pass++;
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_center();
      test_next_wrap();
      test_clamp();
      test_lost();
      test_both_flags();
      test_deadband();
      test_mid_reset();
      test_disable();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/line_follow_ctrl.md
LINE_FOLLOW_CTRL -- requirements
Module: line_follow_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640, image width in pixels; sets the steering zero point IMG_W/2.
REQ-002 SHALL have parameter PWM_PERIOD, default 1000, PWM period in clk cycles.
REQ-003 SHALL have parameter BASE_DUTY, default 600, forward duty in counts.
REQ-004 SHALL have parameter KP_SHIFT, default 1, proportional gain as an arithmetic right shift of the error.
REQ-005 SHALL have parameter DEADBAND, default 8, |error| below this value is treated as 0.
REQ-006 SHALL have parameter LOST_FRAMES, default 8, number of consecutive lost frames before STOP.
REQ-007 SHALL have port clk, input, 1 bit: the video clock, and the only clock.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port enable, input, 1 bit: run request.
REQ-010 SHALL have port frame_done, input, 1 bit: one-cycle pulse when the centroid result for a frame is final.
REQ-011 SHALL have port centroid_x, input, 11 bits: line centroid, unsigned, sampled on frame_done.
REQ-012 SHALL have port line_valid, input, 1 bit, sampled on frame_done.
REQ-013 SHALL have port line_lost, input, 1 bit, sampled on frame_done.
REQ-014 SHALL have port pwm_left, output, 1 bit, and port pwm_right, output, 1 bit: motor PWM outputs.
REQ-015 SHALL have port motor_en, output, 1 bit: driver enable, high in TRACK and COAST only.
REQ-016 SHALL have port state_o, output, 2 bits: current state encoding.
REQ-017 SHALL have port steer_err, output, 12 bits signed: last applied error after the deadband.

Function
REQ-018 SHALL implement states IDLE=0, TRACK=1, COAST=2, STOP=3.
REQ-019 SHALL make these transitions: IDLE->TRACK on enable; TRACK->COAST on a lost frame; COAST->TRACK on a good frame; COAST->STOP when the lost count reaches LOST_FRAMES; STOP->TRACK on a good frame; any state->IDLE on !enable, taking effect on the next cycle.
REQ-020 SHALL treat a frame as good when frame_done & line_valid & !line_lost; any other frame_done is a lost frame, including when line_valid and line_lost are both set.
REQ-021 SHALL compute err = centroid_x - IMG_W/2 as 12-bit signed, force err to 0 if |err| < DEADBAND, and register err on a good frame in TRACK, COAST or STOP.
REQ-022 SHALL compute target duties: left = BASE_DUTY + (err >>> KP_SHIFT) and right = BASE_DUTY - (err >>> KP_SHIFT), in 13-bit signed arithmetic, each clamped to [0, PWM_PERIOD].
REQ-023 SHALL register the target duties 1 cycle after frame_done.
REQ-024 SHALL hold the last duties in COAST, and SHALL use target duties of 0 in STOP and IDLE.
REQ-025 SHALL run a PWM counter 0..PWM_PERIOD-1 that wraps to 0, with pwm_x = (cnt < active_duty_x).
REQ-026 SHALL load active duties from the target duties only on the cycle the counter wraps, so no period is truncated.
REQ-027 SHALL force pwm_left and pwm_right low whenever motor_en is low, regardless of the active duty.
REQ-028 SHALL increment the lost counter on each lost frame in COAST, saturating at LOST_FRAMES, and SHALL clear it on any good frame or on entry to IDLE.
REQ-029 SHALL ignore frame_done while in IDLE.

Reset
REQ-030 SHALL, on synchronous rst: state=IDLE, counter=0, all duties=0, lost count=0, steer_err=0, and pwm_left=pwm_right=motor_en=0 from the cycle after rst is sampled.
REQ-031 SHALL give rst asserted mid-PWM-period priority over every other event, with no partial pulse completed.

Structure
REQ-032 SHALL place the state enum, the 12-bit error type and the duty width constant in package line_ctrl_pkg.
REQ-033 SHALL implement the PWM counter, shadow duty registers and compare in one sub-module, pwm_gen, instantiated once and driving both channels.

Verification (defaults unless noted)
REQ-034 SHALL cover: enable=1, then good frame with centroid_x=320 -> steer_err=0, duties 600/600, pwm high 600 of 1000 cycles on each channel.
REQ-035 SHALL cover: good frame with centroid_x=520 -> err=200, duties 700/500, applied at the next counter wrap, not earlier.
REQ-036 SHALL cover: BASE_DUTY=900, centroid_x=639 -> err=319, shifted 159, left clamped to 1000 (constant high), right=741.
REQ-037 SHALL cover: in TRACK, 7 lost frames -> COAST with duties held; 8th lost frame -> STOP with motor_en=0; then a good frame with centroid_x=330 -> TRACK, err=10, duties 605/595.
REQ-038 SHALL cover: frame_done with line_valid=1 and line_lost=1 -> treated as lost and state=COAST.
REQ-039 SHALL cover: rst or enable=0 asserted mid-period with pwm high -> pwm low and state=IDLE on the next cycle.
